// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 mux: manual select from S, or round-robin auto-scan
// that advances SEL every DIV enabled cycles.
//
// Ports:
//   CLK   in  1           rising-edge clock
//   RST   in  1           asynchronous active-high reset
//   I     in  N*WIDTH     packed inputs, input k at I[k*WIDTH +: WIDTH]
//   S     in  SEL_W       manual select (MODE=0)
//   MODE  in  1           0 = manual, 1 = auto-scan
//   EN    in  1           clock enable, 0 freezes all state
//   O     out WIDTH       registered selected data
//   SEL   out SEL_W       index currently in effect
//   STEP  out 1           pulse when auto-scan advances SEL
//   ERR   out 1           out-of-range manual select seen on last edge
module mux_scan_nto1 #(
    parameter int WIDTH = 3,
    parameter int N     = 5,
    parameter int SEL_W = 3,
    parameter int DIV   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N*WIDTH-1:0] I,
    input  logic [SEL_W-1:0]   S,
    input  logic               MODE,
    input  logic               EN,
    output logic [WIDTH-1:0]   O,
    output logic [SEL_W-1:0]   SEL,
    output logic               STEP,
    output logic               ERR
);

    localparam int PW = (DIV <= 1) ? 1 : $clog2(DIV);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
    localparam logic [PW-1:0]    PRE_TOP  = PW'(DIV - 1);

    logic [WIDTH-1:0] o_q,    o_d;
    logic [SEL_W-1:0] sel_q,  sel_d;
    logic             step_q, step_d;
    logic             err_q,  err_d;
    logic [PW-1:0]    pre_q,  pre_d;

    logic             s_valid;
    logic [WIDTH-1:0] man_data;
    logic [WIDTH-1:0] auto_data;
    logic [SEL_W-1:0] sel_inc;

    assign s_valid = (S <= LAST_IDX);

    // Compare-based mux: an out-of-range index simply matches nothing,
    // so no slice of I is ever addressed past input N-1.
    always_comb begin
        man_data  = '0;
        auto_data = '0;
        for (int k = 0; k < N; k++) begin
            if (S == SEL_W'(k)) begin
                man_data = I[k*WIDTH +: WIDTH];
            end
            if (sel_q == SEL_W'(k)) begin
                auto_data = I[k*WIDTH +: WIDTH];
            end
        end
    end

    // Wrap at N rather than at 2^SEL_W so SEL never leaves 0..N-1.
    assign sel_inc = (sel_q == LAST_IDX) ? '0 : sel_q + SEL_W'(1);

    always_comb begin
        o_d    = o_q;
        sel_d  = sel_q;
        step_d = step_q;
        err_d  = err_q;
        pre_d  = pre_q;
        if (EN) begin
            if (!MODE) begin
                step_d = 1'b0;
                pre_d  = '0;
                if (s_valid) begin
                    o_d   = man_data;
                    sel_d = S;
                    err_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                o_d   = auto_data;
                err_d = 1'b0;
                if (pre_q == PRE_TOP) begin
                    pre_d  = '0;
                    sel_d  = sel_inc;
                    step_d = 1'b1;
                end else begin
                    pre_d  = pre_q + PW'(1);
                    step_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_q    <= '0;
            sel_q  <= '0;
            step_q <= 1'b0;
            err_q  <= 1'b0;
            pre_q  <= '0;
        end else begin
            o_q    <= o_d;
            sel_q  <= sel_d;
            step_q <= step_d;
            err_q  <= err_d;
            pre_q  <= pre_d;
        end
    end

    assign O    = o_q;
    assign SEL  = sel_q;
    assign STEP = step_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Self-checking bench for mux_scan_nto1 (WIDTH=3, N=5, SEL_W=3, DIV=3).
// Behavioural model plus hand-computed literal expectations.
module tb_mux_scan_nto1;

    localparam int W   = 3;
    localparam int N   = 5;
    localparam int SW  = 3;
    localparam int DIV = 3;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N*W-1:0]  I;
    logic [SW-1:0]   S   = '0;
    logic            MODE = 1'b0;
    logic            EN   = 1'b1;
    logic [W-1:0]    O;
    logic [SW-1:0]   SEL;
    logic            STEP;
    logic            ERR;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    int m_o, m_sel, m_step, m_err, m_dwell;

    mux_scan_nto1 #(.WIDTH(W), .N(N), .SEL_W(SW), .DIV(DIV)) dut (
        .CLK (CLK),
        .RST (RST),
        .I   (I),
        .S   (S),
        .MODE(MODE),
        .EN  (EN),
        .O   (O),
        .SEL (SEL),
        .STEP(STEP),
        .ERR (ERR)
    );

    always #5 CLK = ~CLK;

    function automatic int inp(input int k);
        logic [N*W-1:0] v;
        v = I >> (k * W);
        return int'(v[W-1:0]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: m_dwell counts enabled auto cycles spent on the current index.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_o = 0; m_sel = 0; m_step = 0; m_err = 0; m_dwell = 0;
        end else if (EN) begin
            if (!MODE) begin
                m_step  = 0;
                m_dwell = 0;
                if (int'(S) < N) begin
                    m_o = inp(int'(S)); m_sel = int'(S); m_err = 0;
                end else begin
                    m_err = 1;
                end
            end else begin
                m_o     = inp(m_sel);
                m_err   = 0;
                m_dwell = m_dwell + 1;
                m_step  = (m_dwell == DIV) ? 1 : 0;
                if (m_dwell == DIV) begin
                    m_dwell = 0;
                    m_sel   = (m_sel + 1) % N;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            check("model_O",    int'(O),    m_o);
            check("model_SEL",  int'(SEL),  m_sel);
            check("model_STEP", int'(STEP), m_step);
            check("model_ERR",  int'(ERR),  m_err);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic chk_all(input string tag, input int o, input int sel,
                           input int stp, input int err);
        check({tag, "_O"},    int'(O),    o);
        check({tag, "_SEL"},  int'(SEL),  sel);
        check({tag, "_STEP"}, int'(STEP), stp);
        check({tag, "_ERR"},  int'(ERR),  err);
    endtask

    initial begin
        I = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        edges(2);
        chk_all("rst_hold", 0, 0, 0, 0);
        RST = 1'b0;
        chk_on = 1'b1;

        // Manual select 0..4
        for (int k = 0; k < N; k++) begin
            S = SW'(k);
            edges(1);
            chk_all($sformatf("man%0d", k), k, k, 0, 0);
        end

        // Out-of-range selects hold O/SEL and raise ERR
        S = 3'd2;
        edges(1);
        for (int k = 5; k < 8; k++) begin
            S = SW'(k);
            edges(1);
            chk_all($sformatf("oor%0d", k), 2, 2, 0, 1);
        end
        S = 3'd1;
        edges(1);
        chk_all("oor_recover", 1, 1, 0, 0);

        // Different data pattern in manual mode
        I = {3'd7, 3'd5, 3'd6, 3'd1, 3'd3};
        S = 3'd3;
        edges(1);
        check("pat_O", int'(O), 5);
        S = 3'd4;
        edges(1);
        check("pat2_O", int'(O), 7);
        I = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

        // Reset mid-cycle, asynchronous
        RST = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        #2;
        RST = 1'b0;
        MODE = 1'b1;

        // Auto wrap from reset with a 5-cycle freeze at SEL=2, dwell 1
        for (int e = 1; e <= 16; e++) begin
            edges(1);
            chk_all($sformatf("auto%0d", e), ((e - 1) / 3) % 5,
                    (e / 3) % 5, (e % 3 == 0) ? 1 : 0, 0);
            if (e == 7) begin
                EN = 1'b0;
                for (int f = 0; f < 5; f++) begin
                    edges(1);
                    chk_all($sformatf("frz%0d", f), 2, 2, 0, 0);
                end
                EN = 1'b1;
            end
        end

        // ERR raised in manual, cleared by auto
        MODE = 1'b0;
        S = 3'd6;
        edges(1);
        check("err_set", int'(ERR), 1);
        MODE = 1'b1;
        edges(1);
        check("err_auto_clr", int'(ERR), 0);

        // Manual S=3 then auto: advance to 4 after DIV cycles
        MODE = 1'b0;
        S = 3'd3;
        edges(1);
        chk_all("sw_man", 3, 3, 0, 0);
        MODE = 1'b1;
        edges(1);
        chk_all("sw_a1", 3, 3, 0, 0);
        edges(1);
        chk_all("sw_a2", 3, 3, 0, 0);
        edges(1);
        chk_all("sw_a3", 3, 4, 1, 0);
        edges(1);
        chk_all("sw_a4", 4, 4, 0, 0);

        // Reset pulse mid-scan, restart from 0 with full dwell
        RST = 1'b1;
        #1;
        chk_all("rst_scan", 0, 0, 0, 0);
        #2;
        RST = 1'b0;
        edges(2);
        chk_all("rs_a2", 0, 0, 0, 0);
        edges(1);
        chk_all("rs_a3", 0, 1, 1, 0);
        edges(1);
        chk_all("rs_a4", 1, 1, 0, 0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_scan_nto1.md
# mux_scan_nto1

Registered, parametrised N-to-1 multiplexer with two modes: manual selection from the `S` port, or automatic round-robin scanning of the inputs at a programmable rate. It is the sequential successor to the fixed 3-bit 5-to-1 combinational mux. It drives display and monitor paths that must time-share one output bus across several sources. Out-of-range selects are defined: the output holds and an error flag is raised.

## Interface
- `WIDTH`, 3: bit width of each data input and of `O`.
- `N`, 5: number of inputs; N >= 2.
- `SEL_W`, 3: width of `S` and `SEL`; 2^SEL_W >= N.
- `DIV`, 4: clock cycles per scan step in auto mode; DIV >= 1.
- `CLK`  in  1: single clock, rising-edge.
- `RST`  in  1: asynchronous, active-high reset.
- `I`  in  N*WIDTH: packed inputs; input k occupies `I[k*WIDTH +: WIDTH]`.
- `S`  in  SEL_W: manual select, used when MODE=0.
- `MODE`  in  1: 0 = manual, 1 = auto-scan.
- `EN`  in  1: clock enable; 0 freezes all state.
- `O`  out  WIDTH: registered selected data.
- `SEL`  out  SEL_W: index currently in effect (registered).
- `STEP`  out  1: one-cycle pulse when auto-scan advances `SEL`.
- `ERR`  out  1: registered flag; high for a cycle after an out-of-range manual select.

## Operation
- Reset (async, RST=1) sets O=0, SEL=0, STEP=0, ERR=0 and prescaler=0 immediately, independent of CLK.
- EN=0 makes all registers hold, including O, SEL, prescaler, STEP and ERR.
- Manual mode (MODE=1'b0, EN=1), at each edge:
  - S < N: O <= input[S], SEL <= S, ERR <= 0.
  - S >= N: O holds, SEL holds, ERR <= 1.
  - STEP <= 0 and prescaler <= 0.
- Auto mode (MODE=1'b1, EN=1), at each edge:
  - O <= input[SEL], using the SEL value before the edge.
  - ERR <= 0; S is ignored.
  - Prescaler counts 0..DIV-1.
  - When prescaler == DIV-1: prescaler <= 0, SEL <= (SEL == N-1) ? 0 : SEL+1, STEP <= 1.
  - Otherwise: prescaler <= prescaler+1, STEP <= 0.
  - DIV=1: SEL advances every enabled cycle and STEP stays high.
- Manual to auto: scanning starts from the current SEL with prescaler 0. The first advance occurs DIV enabled cycles after the switch.
- Auto to manual: takes effect at the next edge; the prescaler is cleared.
- Prescaler width is clog2(DIV), minimum 1 bit. SEL arithmetic wraps at N, never at 2^SEL_W.
- SEL never holds a value >= N.

## Timing
- Manual latency: S/I change to O is one edge. O is valid the cycle after the edge that samples S.
- Auto: O lags SEL by one cycle. O shows input[k] during the cycle after SEL==k was sampled.
- Each index is shown for DIV consecutive enabled cycles. A full scan period is N*DIV enabled cycles.
- STEP is high in the same cycle that the new SEL value is visible.
- ERR is high in the cycle after the offending edge. It clears at the next enabled edge with a valid S or in auto mode.
- Reset asserted mid-scan: outputs go to reset values asynchronously. After deassertion, scanning restarts from index 0 with a full DIV dwell.
- RST has priority over EN and MODE.

## Test plan
- **Reset:** assert RST mid-cycle with arbitrary I -> O=0, SEL=0, STEP=0, ERR=0 before the next CLK edge.
- **Manual select:** N=5, WIDTH=3, I={3'd4,3'd3,3'd2,3'd1,3'd0}; S=0,1,2,3,4 on successive edges -> O=0,1,2,3,4 one cycle later; SEL tracks S; ERR=0.
- **Out of range:** after S=2 (O=2), drive S=5, 6, 7 -> O stays 2, SEL stays 2, ERR=1 each following cycle; then S=1 -> O=1, ERR=0.
- **Auto wrap:** MODE=1, DIV=3 from reset -> SEL sequence 0,0,0,1,1,1,...,4,4,4,0; STEP pulses on each change, including 4->0; O = input[SEL] delayed one cycle.
- **Enable freeze:** during auto at SEL=2, prescaler=1, drop EN for 5 cycles -> O, SEL and STEP frozen; after EN returns, the advance to 3 occurs 2 cycles later.
- **Mode switch and reset mid-scan:** switch manual (S=3) to auto -> first STEP to SEL=4 after DIV cycles; then pulse RST -> SEL=0 and scan restarts from 0.
